// File: rtl/prog_loader.sv
// Program loader: streams bytes from a host into a small RAM and releases the CPU from clear once the RAM is loaded.
// Optional checksum byte and CHECK/ERROR states are built when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] addr,
  input  logic              LOW_RAM_OE,
  output logic [7:0]        data,
  output logic              cpu_clr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] wr_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_in_ready;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_mem [2**ADDR_W];
  logic              w_beat;
  logic              w_load_start;
  logic              w_last;
  logic              w_oe;

  assign w_beat       = in_valid & r_in_ready;
  assign w_last       = (r_wr_addr == '1);
  assign w_load_start = start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERROR));

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;

  always_ff @(posedge clk) begin
    if (clr || w_load_start) begin
      r_sum <= '0;
    end else if (w_beat && r_state == S_LOAD) begin
      r_sum <= r_sum + in_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_LOAD:  if (w_beat && w_last) w_next = S_CHECK;
      S_CHECK: if (w_beat) w_next = (in_data == r_sum) ? S_DONE : S_ERROR;
`else
      S_LOAD:  if (w_beat && w_last) w_next = S_DONE;
`endif
      S_DONE:  if (start) w_next = S_LOAD;
      S_ERROR: if (start) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state == S_LOAD) | (r_state == S_CHECK);
    done    = (r_state == S_DONE);
    cpu_clr = (r_state != S_DONE);
    w_oe    = (r_state == S_DONE) & ~LOW_RAM_OE;
`ifdef PROG_LOADER_CHECKSUM_EN
    err     = (r_state == S_ERROR);
`else
    err     = 1'b0;
`endif
  end

  // Ready is registered from the next state so it tracks the state register exactly.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_in_ready <= 1'b0;
    end else begin
      r_in_ready <= (w_next == S_LOAD) | (w_next == S_CHECK);
    end
  end

  always_ff @(posedge clk) begin
    if (clr || w_load_start) begin
      r_wr_addr <= '0;
    end else if (w_beat && r_state == S_LOAD) begin
      r_wr_addr <= r_wr_addr + ADDR_W'(1);
    end
  end

  // No reset on the array: contents survive clr.
  always_ff @(posedge clk) begin
    if (!clr && w_beat && r_state == S_LOAD) begin
      r_mem[r_wr_addr] <= in_data;
    end
  end

  assign in_ready = r_in_ready;
  assign wr_addr  = r_wr_addr;
  assign data     = w_oe ? r_mem[addr] : 'z;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: driver queues expected responses, a negedge monitor compares them.
// Build with PROG_LOADER_CHECKSUM_EN defined to exercise the checksum path as well.
module tb_prog_loader;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  // Undriven bus is pulled high, so a released bus reads as all ones.
  localparam logic [7:0]  BUS_Z = 8'hFF;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] addr = '0;
  logic          LOW_RAM_OE = 1'b1;
  tri1  [7:0]    w_data;
  logic          cpu_clr, busy, done, err;
  logic [AW-1:0] wr_addr;

  prog_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .clr(clr), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .addr(addr), .LOW_RAM_OE(LOW_RAM_OE), .data(w_data),
    .cpu_clr(cpu_clr), .busy(busy), .done(done), .err(err), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] val;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_err = 0;
  logic [7:0] model_mem [DEPTH];
  logic [7:0] stim [DEPTH];
  logic [7:0] model_sum;

  // Monitor: compare every queued expectation against the DUT, away from the active edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t       e;
      logic [7:0] got;
      e = sb.pop_front();
      case (e.sel)
        0:       got = w_data;
        1:       got = {7'b0, cpu_clr};
        2:       got = {7'b0, in_ready};
        3:       got = {7'b0, busy};
        4:       got = {7'b0, done};
        5:       got = {7'b0, err};
        default: got = {4'b0, wr_addr};
      endcase
      n_checks++;
      if (got !== e.val) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", e.name, got, e.val);
      end
    end
  end

  task automatic expect_sig(input string name, input int sel, input logic [7:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_status(input string tag, input bit is_done, input bit is_err,
                               input bit is_busy);
    expect_sig({tag, "_done"}, 4, {7'b0, is_done});
    expect_sig({tag, "_err"}, 5, {7'b0, is_err});
    expect_sig({tag, "_busy"}, 3, {7'b0, is_busy});
    expect_sig({tag, "_in_ready"}, 2, {7'b0, is_busy});
    expect_sig({tag, "_cpu_clr"}, 1, {7'b0, !is_done});
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    model_sum = '0;
    expect_status(tag, 1'b0, 1'b0, 1'b1);
    expect_sig({tag, "_wr_addr0"}, 6, 8'h00);
  endtask

  // Stream stim[0..n-1] (plus an optional checksum byte), counting beats as in_valid & in_ready.
  task automatic load(input string tag, input int n, input bit rnd_valid, input bit rnd_start,
                      input bit with_chk, input logic [7:0] chk);
    int idx   = 0;
    int cyc   = 0;
    int total = n + (with_chk ? 1 : 0);
    bit beat;
    while (idx < total && cyc < 400) begin
      in_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = (idx < n) ? stim[idx] : chk;
      start    = rnd_start ? ($urandom_range(0, 3) == 0) : 1'b0;
      beat     = in_valid && in_ready;
      tick();
      cyc++;
      if (beat) begin
        if (idx < n) begin
          model_mem[idx] = stim[idx];
          model_sum      = model_sum + stim[idx];
        end
        idx++;
        if (idx < total) expect_sig({tag, "_not_done_yet"}, 4, 8'h00);
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (idx < total) begin
      n_checks++;
      n_err++;
      $display("FAIL %s_timeout: got %0d beats expected %0d", tag, idx, total);
    end
  endtask

  task automatic finish_status(input string tag, input bit good);
    expect_status(tag, good, !good, 1'b0);
    expect_sig({tag, "_wr_addr_wrap"}, 6, 8'h00);
    settle();
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      addr       = AW'(a);
      LOW_RAM_OE = 1'b0;
      expect_sig($sformatf("%s_rd%0d", tag, a), 0, model_mem[a]);
      settle();
    end
    LOW_RAM_OE = 1'b1;
    addr       = AW'($urandom_range(0, DEPTH - 1));
    expect_sig({tag, "_oe_high_z"}, 0, BUS_Z);
    settle();
  endtask

  task automatic full_load(input string tag, input bit rnd_valid, input bit rnd_start);
    logic [7:0] chk;
    load(tag, DEPTH, rnd_valid, rnd_start, 1'b0, 8'h00);
    chk = model_sum;
    if (CHK) load({tag, "_chk"}, 0, rnd_valid, rnd_start, 1'b1, chk);
    finish_status(tag, 1'b1);
    read_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_sum = '0;

    // Reset: idle, CPU held, bus released even with OE asserted.
    clr = 1'b1;
    tick();
    tick();
    clr        = 1'b0;
    addr       = 4'd5;
    LOW_RAM_OE = 1'b0;
    expect_status("reset", 1'b0, 1'b0, 1'b0);
    expect_sig("reset_wr_addr", 6, 8'h00);
    expect_sig("reset_data_z", 0, BUS_Z);
    settle();
    LOW_RAM_OE = 1'b1;

    // start together with in_valid: transition only, byte 0xEE must not land.
    in_valid = 1'b1;
    in_data  = 8'hEE;
    do_start("start_valid");
    in_valid = 1'b0;
    settle();

    // Incrementing stream with in_valid held high.
    for (int i = 0; i < DEPTH; i++) stim[i] = 8'(8'h10 + i);
    full_load("inc", 1'b0, 1'b0);
    addr       = 4'd5;
    LOW_RAM_OE = 1'b0;
    expect_sig("inc_addr5", 0, 8'h15);
    settle();
    LOW_RAM_OE = 1'b1;

    // Wrong checksum leaves the CPU held and the bus released.
    if (CHK) begin
      do_start("badchk_start");
      load("badchk", DEPTH, 1'b0, 1'b0, 1'b0, 8'h00);
      load("badchk_chk", 0, 1'b0, 1'b0, 1'b1, ~model_sum);
      finish_status("badchk", 1'b0);
      addr       = 4'd5;
      LOW_RAM_OE = 1'b0;
      expect_sig("badchk_data_z", 0, BUS_Z);
      settle();
      LOW_RAM_OE = 1'b1;
    end

    // Random data, random in_valid, spurious start pulses during the load.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) stim[i] = 8'($urandom_range(0, 255));
      do_start($sformatf("rnd%0d_start", r));
      full_load($sformatf("rnd%0d", r), 1'b1, 1'b1);
    end

    // Abort after 7 beats; clr wins over a simultaneous beat and start.
    for (int i = 0; i < DEPTH; i++) stim[i] = 8'($urandom_range(0, 255));
    do_start("abort_start");
    load("abort", 7, 1'b0, 1'b0, 1'b0, 8'h00);
    clr      = 1'b1;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    tick();
    clr      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    expect_status("abort", 1'b0, 1'b0, 1'b0);
    expect_sig("abort_wr_addr", 6, 8'h00);
    settle();
    for (int i = 0; i < DEPTH; i++) stim[i] = 8'(8'hA0 + i);
    do_start("reload_a_start");
    full_load("reload_a", 1'b1, 1'b0);

    // Reload from DONE with zeros.
    for (int i = 0; i < DEPTH; i++) stim[i] = 8'h00;
    do_start("zero_start");
    full_load("zero", 1'b0, 1'b0);

    settle();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
